// File: rtl/parallel_traffic_source_if.sv
// Local-port bundle between a traffic source and its router: req/busy handshake plus status.
// stall_cycles exists only when SRC_STALL_CNT_EN is defined.
interface parallel_traffic_source_if #(
    parameter int DW = 20
);
    logic          send;
    logic          busy;
    logic          req;
    logic [DW-1:0] data;
    logic          done;
    logic [15:0]   tx_count;
`ifdef SRC_STALL_CNT_EN
    logic [15:0]   stall_cycles;
`endif

    modport master (
        input  send,
        input  busy,
        output req,
        output data,
        output done,
        output tx_count
`ifdef SRC_STALL_CNT_EN
        , output stall_cycles
`endif
    );

    modport slave (
        output send,
        output busy,
        input  req,
        input  data,
        input  done,
        input  tx_count
`ifdef SRC_STALL_CNT_EN
        , input  stall_cycles
`endif
    );
endinterface

// File: rtl/parallel_traffic_source.sv
// NoC single-flit injector (list/random/fixed dest, LFSR-gated rate); req one edge after firing GEN, max 1 flit/3 cycles.
// Holds req/data until busy=0; optional stall counter under SRC_STALL_CNT_EN.
module parallel_traffic_source #(
    parameter int          ID           = 0,
    parameter int          ADDR_BITS    = 4,
    parameter int          PAYLOAD_SIZE = 16,
    parameter int          NUM_NODES    = 16,
    parameter int          MODE         = 0,
    parameter int          DESTS        = 1,
    parameter int          LOOP         = 1,
    parameter int          DEST         = 0,
    parameter int          PIR          = 256,
    parameter int          MAX_PKTS     = 0,
    parameter logic [15:0] SEED         = 16'hACE1,
    parameter string       TRAFFIC_FILE = "",
    // Destination list; entry i at [i*ADDR_BITS +: ADDR_BITS]
    parameter logic [DESTS*ADDR_BITS-1:0] DEST_LIST = '0
) (
    input  logic clk,
    input  logic reset,
    parallel_traffic_source_if.master bus
);
    localparam int          DW       = PAYLOAD_SIZE + ADDR_BITS;
    localparam int          SEQ_W    = PAYLOAD_SIZE - ADDR_BITS;
    localparam int          IDX_W    = (DESTS > 1) ? $clog2(DESTS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DESTS - 1);
    localparam logic [15:0] SEED_X   = SEED ^ 16'(ID);
    localparam logic [15:0] EFF_SEED = (SEED_X == 16'h0000) ? 16'h0001 : SEED_X;

    typedef enum logic [2:0] {IDLE, GEN, REQ, GAP, DONE} state_t;

    logic [ADDR_BITS-1:0] mem [DESTS];

    generate
        for (genvar i = 0; i < DESTS; i++) begin : g_ent
            assign mem[i] = DEST_LIST[i*ADDR_BITS +: ADDR_BITS];
        end
    endgenerate

    state_t               state;
    logic [15:0]          lfsr;
    logic [IDX_W-1:0]     index;
    logic                 eol;
    logic                 req_q;
    logic                 done_q;
    logic [DW-1:0]        data_q;
    logic [15:0]          tx_cnt;

    logic                 fb;
    logic                 fire;
    logic [ADDR_BITS-1:0] cand;
    logic                 cand_ok;
    logic                 limit_hit;
    logic [SEQ_W-1:0]     seq;

    assign fb        = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
    assign fire      = ({1'b0, lfsr[7:0]} < 9'(PIR));
    assign limit_hit = (MAX_PKTS != 0) && (tx_cnt == 16'(MAX_PKTS));
    assign seq       = SEQ_W'(tx_cnt);

    always_comb begin
        cand    = ADDR_BITS'(DEST);
        cand_ok = 1'b1;
        case (MODE)
            0: cand = mem[index];
            1: begin
                cand    = lfsr[15 -: ADDR_BITS];
                cand_ok = (32'(cand) < 32'(NUM_NODES)) && (32'(cand) != 32'(ID));
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            lfsr   <= EFF_SEED;
            index  <= '0;
            eol    <= 1'b0;
            req_q  <= 1'b0;
            done_q <= 1'b0;
            data_q <= '0;
            tx_cnt <= '0;
        end else begin
            lfsr <= {lfsr[14:0], fb};
            case (state)
                IDLE: if (bus.send && !done_q) state <= GEN;
                GEN: begin
                    if (!bus.send) begin
                        state <= IDLE;
                    end else if (fire && cand_ok) begin
                        data_q <= {seq, ADDR_BITS'(ID), cand};
                        req_q  <= 1'b1;
                        state  <= REQ;
                    end
                end
                // send is deliberately ignored here: an offered flit is never withdrawn
                REQ: begin
                    if (!bus.busy) begin
                        req_q  <= 1'b0;
                        tx_cnt <= tx_cnt + 16'd1;
                        if (MODE == 0) begin
                            if (index == LAST_IDX) begin
                                if (LOOP != 0) index <= '0;
                                else           eol   <= 1'b1;
                            end else begin
                                index <= index + IDX_W'(1);
                            end
                        end
                        state <= GAP;
                    end
                end
                GAP: begin
                    if (limit_hit || eol) begin
                        done_q <= 1'b1;
                        state  <= DONE;
                    end else begin
                        state <= GEN;
                    end
                end
                DONE:    ;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req      = req_q;
    assign bus.data     = data_q;
    assign bus.done     = done_q;
    assign bus.tx_count = tx_cnt;

`ifdef SRC_STALL_CNT_EN
    logic [15:0] stall_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_q <= '0;
        end else if (req_q && bus.busy && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign bus.stall_cycles = stall_q;
`endif
endmodule
